mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters (fetch and memory stage) and the shared bus.
// Requests are levels held until the matching one-cycle ack; the bus side completes on bus_arb_ack.
interface mem_arbiter_if;
    logic        if_arb_req;
    logic [31:0] if_arb_addr;
    logic [31:0] arb_if_data;
    logic        arb_if_ack;

    logic        mem_arb_req;
    logic        mem_arb_write;
    logic [31:0] mem_arb_addr;
    logic [31:0] mem_arb_wdata;
    logic [31:0] arb_mem_rdata;
    logic        arb_mem_ack;

    logic        arb_bus_req;
    logic        arb_bus_write;
    logic [31:0] arb_bus_addr;
    logic [31:0] arb_bus_wdata;
    logic [31:0] bus_arb_rdata;
    logic        bus_arb_ack;

    logic        arb_stall;
    logic        arb_timeout;
    logic [1:0]  arb_state;

    modport master (
        input  if_arb_req, if_arb_addr,
        output arb_if_data, arb_if_ack,
        input  mem_arb_req, mem_arb_write, mem_arb_addr, mem_arb_wdata,
        output arb_mem_rdata, arb_mem_ack,
        output arb_bus_req, arb_bus_write, arb_bus_addr, arb_bus_wdata,
        input  bus_arb_rdata, bus_arb_ack,
        output arb_stall, arb_timeout, arb_state
    );

    modport slave (
        output if_arb_req, if_arb_addr,
        input  arb_if_data, arb_if_ack,
        output mem_arb_req, mem_arb_write, mem_arb_addr, mem_arb_wdata,
        input  arb_mem_rdata, arb_mem_ack,
        input  arb_bus_req, arb_bus_write, arb_bus_addr, arb_bus_wdata,
        output bus_arb_rdata, bus_arb_ack,
        input  arb_stall, arb_timeout, arb_state
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto a single-outstanding memory bus: MEM priority with
// an IF starvation guard, a 15-edge bus timeout, and a sticky timeout flag.
module mem_arbiter (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.master arb
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY_IF  = 2'd1;
    localparam logic [1:0] BUSY_MEM = 2'd2;

    logic [1:0]  state;
    logic [1:0]  if_starve;
    logic [3:0]  wait_cnt;
    logic        bus_req, bus_write;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] if_data, mem_rdata;
    logic        if_ack, mem_ack, timeout;

    logic if_ok, mem_ok, grant_if, grant_mem;

    // A requester whose ack is high this cycle is still holding its old request.
    always_comb begin
        if_ok     = arb.if_arb_req  && !if_ack;
        mem_ok    = arb.mem_arb_req && !mem_ack;
        grant_if  = if_ok && (!mem_ok || (if_starve == 2'd3));
        grant_mem = mem_ok && !grant_if;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            if_starve <= 2'd0;
            wait_cnt  <= 4'd0;
            bus_req   <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        state     <= BUSY_MEM;
                        bus_req   <= 1'b1;
                        bus_write <= arb.mem_arb_write;
                        bus_addr  <= arb.mem_arb_addr;
                        bus_wdata <= arb.mem_arb_wdata;
                        wait_cnt  <= 4'd0;
                        if (if_ok) if_starve <= if_starve + 2'd1;
                    end else if (grant_if) begin
                        state     <= BUSY_IF;
                        bus_req   <= 1'b1;
                        bus_write <= 1'b0;
                        bus_addr  <= arb.if_arb_addr;
                        bus_wdata <= 32'd0;
                        wait_cnt  <= 4'd0;
                        if_starve <= 2'd0;
                    end
                end
                BUSY_IF, BUSY_MEM: begin
                    if (arb.bus_arb_ack) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        if (state == BUSY_IF) begin
                            if_data <= arb.bus_arb_rdata;
                            if_ack  <= 1'b1;
                        end else begin
                            if (!bus_write) mem_rdata <= arb.bus_arb_rdata;
                            mem_ack <= 1'b1;
                        end
                    end else if (wait_cnt == 4'd14) begin
                        // Abort: the requester still gets its ack, with zero data.
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        timeout <= 1'b1;
                        if (state == BUSY_IF) begin
                            if_data <= 32'd0;
                            if_ack  <= 1'b1;
                        end else begin
                            mem_rdata <= 32'd0;
                            mem_ack   <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb.arb_if_data   = if_data;
    assign arb.arb_if_ack    = if_ack;
    assign arb.arb_mem_rdata = mem_rdata;
    assign arb.arb_mem_ack   = mem_ack;
    assign arb.arb_bus_req   = bus_req;
    assign arb.arb_bus_write = bus_write;
    assign arb.arb_bus_addr  = bus_addr;
    assign arb.arb_bus_wdata = bus_wdata;
    assign arb.arb_timeout   = timeout;
    assign arb.arb_state     = state;
    assign arb.arb_stall     = (arb.if_arb_req && !if_ack) || (arb.mem_arb_req && !mem_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: linear stimulus with hand-computed expectations.
module tb_mem_arbiter;
    logic clock;
    logic reset;
    mem_arbiter_if ifc();

    mem_arbiter dut (
        .clock (clock),
        .reset (reset),
        .arb   (ifc)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BUSY_IF  = 2'd1;
    localparam logic [1:0] S_BUSY_MEM = 2'd2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_bus_req"},   {31'd0, ifc.arb_bus_req},   32'd0);
        chk({tag, "_bus_write"}, {31'd0, ifc.arb_bus_write}, 32'd0);
        chk({tag, "_bus_addr"},  ifc.arb_bus_addr,           32'd0);
        chk({tag, "_bus_wdata"}, ifc.arb_bus_wdata,          32'd0);
        chk({tag, "_if_data"},   ifc.arb_if_data,            32'd0);
        chk({tag, "_mem_rdata"}, ifc.arb_mem_rdata,          32'd0);
        chk({tag, "_if_ack"},    {31'd0, ifc.arb_if_ack},    32'd0);
        chk({tag, "_mem_ack"},   {31'd0, ifc.arb_mem_ack},   32'd0);
        chk({tag, "_timeout"},   {31'd0, ifc.arb_timeout},   32'd0);
        chk({tag, "_state"},     {30'd0, ifc.arb_state},     {30'd0, S_IDLE});
    endtask

    initial begin
        reset = 1'b1;
        ifc.if_arb_req    = 1'b0;
        ifc.if_arb_addr   = 32'd0;
        ifc.mem_arb_req   = 1'b0;
        ifc.mem_arb_write = 1'b0;
        ifc.mem_arb_addr  = 32'd0;
        ifc.mem_arb_wdata = 32'd0;
        ifc.bus_arb_rdata = 32'd0;
        ifc.bus_arb_ack   = 1'b0;
        tick();
        tick();
        chk_zero_outputs("reset");
        chk("reset_stall", {31'd0, ifc.arb_stall}, 32'd0);
        reset = 1'b0;

        // IF-only read, bus ack two cycles after bus_req
        ifc.if_arb_req  = 1'b1;
        ifc.if_arb_addr = 32'h100;
        #1;
        chk("if_stall_pending", {31'd0, ifc.arb_stall}, 32'd1);
        tick();
        chk("if_grant_state", {30'd0, ifc.arb_state}, {30'd0, S_BUSY_IF});
        chk("if_bus_req", {31'd0, ifc.arb_bus_req}, 32'd1);
        chk("if_bus_addr", ifc.arb_bus_addr, 32'h100);
        chk("if_bus_write", {31'd0, ifc.arb_bus_write}, 32'd0);
        tick();
        chk("if_wait_bus_req", {31'd0, ifc.arb_bus_req}, 32'd1);
        ifc.bus_arb_ack   = 1'b1;
        ifc.bus_arb_rdata = 32'hDEADBEEF;
        tick();
        ifc.bus_arb_ack = 1'b0;
        chk("if_ack_pulse", {31'd0, ifc.arb_if_ack}, 32'd1);
        chk("if_data", ifc.arb_if_data, 32'hDEADBEEF);
        chk("if_done_bus_req", {31'd0, ifc.arb_bus_req}, 32'd0);
        chk("if_done_state", {30'd0, ifc.arb_state}, {30'd0, S_IDLE});
        chk("if_stall_during_ack", {31'd0, ifc.arb_stall}, 32'd0);
        tick();
        ifc.if_arb_req = 1'b0;
        chk("if_ack_one_cycle", {31'd0, ifc.arb_if_ack}, 32'd0);
        chk("if_no_regrant", {30'd0, ifc.arb_state}, {30'd0, S_IDLE});

        // Simultaneous requests: MEM write first, then IF
        ifc.mem_arb_req   = 1'b1;
        ifc.mem_arb_write = 1'b1;
        ifc.mem_arb_addr  = 32'h200;
        ifc.mem_arb_wdata = 32'h55;
        ifc.if_arb_req    = 1'b1;
        ifc.if_arb_addr   = 32'h300;
        tick();
        chk("sim_mem_state", {30'd0, ifc.arb_state}, {30'd0, S_BUSY_MEM});
        chk("sim_mem_write", {31'd0, ifc.arb_bus_write}, 32'd1);
        chk("sim_mem_addr", ifc.arb_bus_addr, 32'h200);
        chk("sim_mem_wdata", ifc.arb_bus_wdata, 32'h55);
        ifc.bus_arb_ack   = 1'b1;
        ifc.bus_arb_rdata = 32'h1234;
        tick();
        ifc.bus_arb_ack = 1'b0;
        ifc.mem_arb_req = 1'b0;
        chk("sim_mem_ack", {31'd0, ifc.arb_mem_ack}, 32'd1);
        chk("sim_write_keeps_rdata", ifc.arb_mem_rdata, 32'd0);
        chk("sim_idle_between", {30'd0, ifc.arb_state}, {30'd0, S_IDLE});
        tick();
        chk("sim_if_state", {30'd0, ifc.arb_state}, {30'd0, S_BUSY_IF});
        chk("sim_if_addr", ifc.arb_bus_addr, 32'h300);
        chk("sim_if_write", {31'd0, ifc.arb_bus_write}, 32'd0);
        chk("sim_if_wdata", ifc.arb_bus_wdata, 32'd0);
        ifc.bus_arb_ack   = 1'b1;
        ifc.bus_arb_rdata = 32'hA5A5A5A5;
        tick();
        ifc.bus_arb_ack = 1'b0;
        ifc.if_arb_req  = 1'b0;
        chk("sim_if_data", ifc.arb_if_data, 32'hA5A5A5A5);
        tick();

        // Starvation guard: three MEM wins, IF takes the fourth arbitration
        ifc.if_arb_req    = 1'b1;
        ifc.if_arb_addr   = 32'h400;
        ifc.mem_arb_req   = 1'b1;
        ifc.mem_arb_write = 1'b0;
        ifc.mem_arb_addr  = 32'h500;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("starve_mem_win%0d", k), {30'd0, ifc.arb_state}, {30'd0, S_BUSY_MEM});
            ifc.bus_arb_ack   = 1'b1;
            ifc.bus_arb_rdata = 32'(k + 1);
            tick();
            ifc.bus_arb_ack = 1'b0;
            ifc.if_arb_req  = 1'b0;
            chk($sformatf("starve_mem_rdata%0d", k), ifc.arb_mem_rdata, 32'(k + 1));
            tick();
            chk($sformatf("starve_masked%0d", k), {30'd0, ifc.arb_state}, {30'd0, S_IDLE});
            ifc.if_arb_req = 1'b1;
        end
        tick();
        chk("starve_if_wins", {30'd0, ifc.arb_state}, {30'd0, S_BUSY_IF});
        chk("starve_if_addr", ifc.arb_bus_addr, 32'h400);
        ifc.bus_arb_ack   = 1'b1;
        ifc.bus_arb_rdata = 32'h77;
        tick();
        ifc.bus_arb_ack = 1'b0;
        ifc.if_arb_req  = 1'b0;
        ifc.mem_arb_req = 1'b0;
        chk("starve_if_ack", {31'd0, ifc.arb_if_ack}, 32'd1);
        tick();

        // Timeout: MEM read with a silent bus; requester drops req mid-transaction
        ifc.mem_arb_req  = 1'b1;
        ifc.mem_arb_addr = 32'h600;
        tick();
        ifc.mem_arb_req = 1'b0;
        chk("to_grant", {30'd0, ifc.arb_state}, {30'd0, S_BUSY_MEM});
        for (int k = 0; k < 14; k++) tick();
        chk("to_still_busy", {30'd0, ifc.arb_state}, {30'd0, S_BUSY_MEM});
        chk("to_bus_req_held", {31'd0, ifc.arb_bus_req}, 32'd1);
        chk("to_not_yet", {31'd0, ifc.arb_timeout}, 32'd0);
        tick();
        chk("to_mem_ack", {31'd0, ifc.arb_mem_ack}, 32'd1);
        chk("to_mem_rdata_zero", ifc.arb_mem_rdata, 32'd0);
        chk("to_flag", {31'd0, ifc.arb_timeout}, 32'd1);
        chk("to_bus_req_drop", {31'd0, ifc.arb_bus_req}, 32'd0);
        tick();
        tick();
        chk("to_ack_one_cycle", {31'd0, ifc.arb_mem_ack}, 32'd0);
        chk("to_flag_sticky", {31'd0, ifc.arb_timeout}, 32'd1);

        // Ack on the 15th wait edge beats the timeout
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("to2_flag_cleared", {31'd0, ifc.arb_timeout}, 32'd0);
        ifc.mem_arb_req  = 1'b1;
        ifc.mem_arb_addr = 32'h700;
        tick();
        ifc.mem_arb_req = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        ifc.bus_arb_ack   = 1'b1;
        ifc.bus_arb_rdata = 32'hCAFE;
        tick();
        ifc.bus_arb_ack = 1'b0;
        chk("to2_mem_ack", {31'd0, ifc.arb_mem_ack}, 32'd1);
        chk("to2_rdata", ifc.arb_mem_rdata, 32'hCAFE);
        chk("to2_no_flag", {31'd0, ifc.arb_timeout}, 32'd0);
        tick();

        // Asynchronous reset during BUSY_MEM
        ifc.mem_arb_req   = 1'b1;
        ifc.mem_arb_write = 1'b1;
        ifc.mem_arb_addr  = 32'h800;
        ifc.mem_arb_wdata = 32'h99;
        tick();
        chk("rst_busy_bus_req", {31'd0, ifc.arb_bus_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_zero_outputs("rst_async");
        ifc.mem_arb_req   = 1'b0;
        ifc.mem_arb_write = 1'b0;
        ifc.bus_arb_ack   = 1'b1;
        tick();
        chk("rst_no_mem_ack", {31'd0, ifc.arb_mem_ack}, 32'd0);
        ifc.bus_arb_ack = 1'b0;
        reset = 1'b0;

        // Stray bus ack while IDLE, then combinational stall
        ifc.bus_arb_ack   = 1'b1;
        ifc.bus_arb_rdata = 32'hBAD;
        tick();
        tick();
        chk("stray_if_ack", {31'd0, ifc.arb_if_ack}, 32'd0);
        chk("stray_mem_ack", {31'd0, ifc.arb_mem_ack}, 32'd0);
        chk("stray_state", {30'd0, ifc.arb_state}, {30'd0, S_IDLE});
        chk("stray_if_data", ifc.arb_if_data, 32'd0);
        chk("stall_idle", {31'd0, ifc.arb_stall}, 32'd0);
        ifc.bus_arb_ack = 1'b0;
        ifc.mem_arb_req = 1'b1;
        #1;
        chk("stall_mem_req", {31'd0, ifc.arb_stall}, 32'd1);
        ifc.mem_arb_req = 1'b0;
        #1;
        chk("stall_released", {31'd0, ifc.arb_stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
